// File: rtl/micro_job_ctrl.sv
// Job sequencer for the pairing micro core port: streams operands in, starts the core,
// waits out busy, then streams results back through a credit-limited result FIFO.
module micro_job_ctrl #(
    parameter int PORTW     = 32,
    parameter int SERSZ     = 20,
    parameter int RFSZLOG2  = 8,
    parameter int FUNCIDW   = 8,
    parameter int CORELOG2  = 1,
    parameter int CNTW      = 12,
    parameter int RDQ_DEPTH = 8,
    parameter int BUSY_WIN  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FUNCIDW-1:0]    cmd_funcid,
    input  logic [CORELOG2-1:0]   cmd_chip,
    input  logic [RFSZLOG2-1:0]   cmd_in_base,
    input  logic [CNTW-1:0]       cmd_nin,
    input  logic [RFSZLOG2-1:0]   cmd_out_base,
    input  logic [CNTW-1:0]       cmd_nout,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [PORTW-1:0]      op_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PORTW-1:0]      res_data,
    output logic                  res_last,
    output logic                  job_done,
    output logic [CORELOG2-1:0]   m_chip_sel,
    output logic [FUNCIDW-1:0]    m_funcid,
    output logic                  m_start,
    output logic                  m_wen,
    output logic [RFSZLOG2+4:0]   m_waddr,
    output logic [PORTW-1:0]      m_wdata,
    output logic                  m_ren,
    output logic [RFSZLOG2+4:0]   m_raddr,
    input  logic [PORTW-1:0]      m_rdata,
    input  logic                  m_rdata_valid,
    input  logic                  m_busy
);
    localparam int QAW = $clog2(RDQ_DEPTH);
    localparam int QCW = QAW + 1;
    localparam int WCW = $clog2(BUSY_WIN + 1);
    localparam int PCW = CNTW + 5;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_COMMIT  = 4'd2,
        S_START   = 4'd3,
        S_WAIT_HI = 4'd4,
        S_WAIT_LO = 4'd5,
        S_READ    = 4'd6,
        S_DRAIN   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            beat_q, beat_d;
    logic [CNTW-1:0]       word_q, word_d;
    logic [WCW-1:0]        cnt_q, cnt_d;
    logic [CORELOG2-1:0]   chip_q, chip_d;
    logic [FUNCIDW-1:0]    funcid_q, funcid_d;
    logic [RFSZLOG2-1:0]   in_base_q, in_base_d, out_base_q, out_base_d;
    logic [CNTW-1:0]       nin_q, nin_d, nout_q, nout_d;
    logic [QAW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0]        fifo_cnt_q, fifo_cnt_d, outst_q, outst_d;
    logic [PCW-1:0]        pop_cnt_q, pop_cnt_d;
    logic [PORTW-1:0]      mem_q [RDQ_DEPTH];

    logic                  cmd_fire_s, op_ready_s, wen_s, ren_s, start_s, done_s;
    logic                  push_s, pop_s, last_beat_s;
    logic [RFSZLOG2-1:0]   wword_s, rword_s;
    logic [PCW-1:0]        total_s;

    assign cmd_fire_s  = cmd_valid && (state_q == S_IDLE);
    assign last_beat_s = (beat_q == 5'(SERSZ - 1));
    assign wword_s     = in_base_q + word_q[RFSZLOG2-1:0];
    assign rword_s     = out_base_q + word_q[RFSZLOG2-1:0];
    // Credit: in-flight reads plus queued beats may never exceed the FIFO depth.
    assign ren_s       = (state_q == S_READ) && !m_busy &&
                         (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (QCW+1)'(RDQ_DEPTH));
    assign push_s      = m_rdata_valid && (outst_q != '0);
    assign pop_s       = res_valid && res_ready;
    assign total_s     = PCW'(nout_q) * PCW'(SERSZ);

    assign cmd_ready  = (state_q == S_IDLE);
    assign op_ready   = op_ready_s;
    assign m_start    = start_s;
    assign job_done   = done_s;
    assign m_wen      = wen_s;
    assign m_waddr    = wen_s ? {wword_s, beat_q} : '0;
    assign m_wdata    = wen_s ? op_data : '0;
    assign m_ren      = ren_s;
    assign m_raddr    = ren_s ? {rword_s, beat_q} : '0;
    assign m_chip_sel = chip_q;
    assign m_funcid   = funcid_q;
    assign res_valid  = (fifo_cnt_q != '0);
    assign res_data   = res_valid ? mem_q[rd_ptr_q] : '0;
    assign res_last   = res_valid && (pop_cnt_q == total_s - PCW'(1));

    // Job sequencing: next state, beat/word walk and descriptor latch.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        chip_d     = chip_q;
        funcid_d   = funcid_q;
        in_base_d  = in_base_q;
        nin_d      = nin_q;
        out_base_d = out_base_q;
        nout_d     = nout_q;
        op_ready_s = 1'b0;
        wen_s      = 1'b0;
        start_s    = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire_s) begin
                    chip_d     = cmd_chip;
                    funcid_d   = cmd_funcid;
                    in_base_d  = cmd_in_base;
                    nin_d      = cmd_nin;
                    out_base_d = cmd_out_base;
                    nout_d     = cmd_nout;
                    beat_d     = 5'd0;
                    word_d     = '0;
                    cnt_d      = '0;
                    state_d    = (cmd_nin == '0) ? S_START : S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                op_ready_s = !m_busy;
                if (op_valid && !m_busy) begin
                    wen_s = 1'b1;
                    if (last_beat_s) begin
                        beat_d = 5'd0;
                        word_d = word_q + CNTW'(1);
                        if (word_q == nin_q - CNTW'(1)) begin
                            cnt_d   = '0;
                            state_d = S_COMMIT;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_COMMIT: begin
                if (cnt_q == WCW'(1)) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + WCW'(1);
                end
            end
            S_START: begin
                start_s = 1'b1;
                cnt_d   = WCW'(1);
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // The start cycle counts toward the busy window.
                if (m_busy) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q >= WCW'(BUSY_WIN - 1)) begin
                    beat_d  = 5'd0;
                    word_d  = '0;
                    state_d = (nout_q == '0) ? S_DONE : S_READ;
                end else begin
                    cnt_d = cnt_q + WCW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!m_busy) begin
                    beat_d  = 5'd0;
                    word_d  = '0;
                    state_d = (nout_q == '0) ? S_DONE : S_READ;
                end else begin
                    state_d = S_WAIT_LO;
                end
            end
            S_READ: begin
                if (ren_s) begin
                    if (last_beat_s) begin
                        beat_d  = 5'd0;
                        word_d  = word_q + CNTW'(1);
                        state_d = (word_q == nout_q - CNTW'(1)) ? S_DRAIN : S_READ;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                // Look at the next occupancy so done follows the final pop by one cycle.
                if ((outst_q == '0) && (fifo_cnt_d == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result FIFO pointers, occupancy, in-flight reads and per-job pop count.
    always_comb begin
        wr_ptr_d   = push_s ? wr_ptr_q + QAW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_s ? rd_ptr_q + QAW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + QCW'(push_s) - QCW'(pop_s);
        outst_d    = outst_q + QCW'(ren_s) - QCW'(push_s);
        pop_cnt_d  = cmd_fire_s ? '0 : pop_cnt_q + PCW'(pop_s);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beat_q     <= 5'd0;
            word_q     <= '0;
            cnt_q      <= '0;
            chip_q     <= '0;
            funcid_q   <= '0;
            in_base_q  <= '0;
            nin_q      <= '0;
            out_base_q <= '0;
            nout_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
            pop_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            chip_q     <= chip_d;
            funcid_q   <= funcid_d;
            in_base_q  <= in_base_d;
            nin_q      <= nin_d;
            out_base_q <= out_base_d;
            nout_q     <= nout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            outst_q    <= outst_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy is zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_micro_job_ctrl.sv
// Randomized bench for micro_job_ctrl: a core-port model with RF and read latency,
// and a scoreboard built from the job descriptors and a shadow register file.
module tb_micro_job_ctrl;
    localparam int SERSZ    = 20;
    localparam int BUSY_WIN = 16;
    localparam int RDQ      = 8;

    logic clk, rst_n;
    logic cmd_valid, cmd_ready;
    logic [7:0] cmd_funcid;
    logic [0:0] cmd_chip;
    logic [7:0] cmd_in_base, cmd_out_base;
    logic [11:0] cmd_nin, cmd_nout;
    logic op_valid, op_ready;
    logic [31:0] op_data;
    logic res_valid, res_ready, res_last, job_done;
    logic [31:0] res_data;
    logic [0:0] m_chip_sel;
    logic [7:0] m_funcid;
    logic m_start, m_wen, m_ren, m_rdata_valid, m_busy;
    logic [12:0] m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rdata;

    micro_job_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funcid(cmd_funcid),
        .cmd_chip(cmd_chip), .cmd_in_base(cmd_in_base), .cmd_nin(cmd_nin),
        .cmd_out_base(cmd_out_base), .cmd_nout(cmd_nout),
        .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .job_done(job_done),
        .m_chip_sel(m_chip_sel), .m_funcid(m_funcid), .m_start(m_start),
        .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_ren(m_ren), .m_raddr(m_raddr), .m_rdata(m_rdata),
        .m_rdata_valid(m_rdata_valid), .m_busy(m_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Core port model: RF storage, fixed 4-cycle read latency, scripted busy pulse.
    logic [31:0] core_rf [int];
    logic [31:0] ref_rf [int];
    logic [3:0]  rv_pipe = 4'b0;
    logic [31:0] rd_pipe [4] = '{default: 32'h0};
    int bcnt = 0;
    int busy_dly = 3;
    int busy_len = 0;

    function automatic logic [31:0] core_read(input int a);
        return core_rf.exists(a) ? core_rf[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_read(input int a);
        return ref_rf.exists(a) ? ref_rf[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_wen) core_rf[int'(m_waddr)] = m_wdata;
        rd_pipe[0] <= m_ren ? core_read(int'(m_raddr)) : 32'h0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
        rd_pipe[3] <= rd_pipe[2];
        rv_pipe    <= {rv_pipe[2:0], m_ren};
        if (m_start) bcnt <= 1;
        else if (bcnt != 0 && bcnt < 1000000) bcnt <= bcnt + 1;
    end

    assign m_rdata       = rd_pipe[3];
    assign m_rdata_valid = rv_pipe[3];
    assign m_busy        = (busy_len != 0) && (bcnt >= busy_dly) && (bcnt < busy_dly + busy_len);

    // Scoreboard state.
    int exp_waddr[$];
    logic [31:0] exp_wdata[$];
    int exp_raddr[$];
    logic [31:0] exp_res[$];
    logic [31:0] op_q[$];
    int cur_funcid, cur_chip;
    int start_cnt, ren_cnt, wen_cnt, done_cnt;
    int start_cyc, first_ren_cyc, last_wen_cyc, last_pop_cyc, done_cyc;
    int res_stall = 0;
    bit res_hold = 1'b1;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic prev_last;
    int mon_a;
    logic [31:0] mon_d;

    // Result consumer with random back-pressure.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = !res_hold && ($urandom_range(99) >= res_stall);
        end
    end

    // Mid-cycle monitor of every DUT output.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (m_wen) begin
                wen_cnt++;
                last_wen_cyc = cyc;
                check_eq("wen_excl", {m_busy, m_ren}, 0);
                if (exp_waddr.size() == 0) check_eq("wr_extra", m_wen, 0);
                else begin
                    mon_a = exp_waddr.pop_front();
                    mon_d = exp_wdata.pop_front();
                    check_eq("waddr", m_waddr, mon_a);
                    check_eq("wdata", m_wdata, mon_d);
                end
            end
            if (m_start) begin
                start_cnt++;
                start_cyc = cyc;
                check_eq("funcid", m_funcid, cur_funcid);
                check_eq("chip_sel", m_chip_sel, cur_chip);
                check_eq("wr_left_at_start", exp_waddr.size(), 0);
                if (last_wen_cyc >= 0) check_eq("commit_gap", cyc - last_wen_cyc, 3);
            end
            if (m_ren) begin
                ren_cnt++;
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                check_eq("ren_excl", {m_busy, m_wen}, 0);
                if (exp_raddr.size() == 0) check_eq("rd_extra", m_ren, 0);
                else begin
                    mon_a = exp_raddr.pop_front();
                    check_eq("raddr", m_raddr, mon_a);
                end
            end
            if (prev_stall) begin
                check_eq("hold_valid", res_valid, 1);
                check_eq("hold_data", res_data, prev_data);
                check_eq("hold_last", res_last, prev_last);
            end
            if (res_valid && exp_res.size() == 0) begin
                check_eq("res_spurious", res_valid, 0);
            end else if (res_valid && res_ready) begin
                mon_d = exp_res.pop_front();
                check_eq("res_data", res_data, mon_d);
                check_eq("res_last", res_last, exp_res.size() == 0);
                last_pop_cyc = cyc;
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_last  = res_last;
            if (job_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_job(input int ib, input int ni, input int ob, input int no,
                             input int fid, input int ch, input int op_stall,
                             input int rstall, input int dly, input int len, input bit hold);
        logic [31:0] d;
        int a;
        bit fire;
        for (int w = 0; w < ni; w++)
            for (int b = 0; b < SERSZ; b++) begin
                a = (((ib + w) % 256) << 5) | b;
                d = $urandom;
                op_q.push_back(d);
                exp_waddr.push_back(a);
                exp_wdata.push_back(d);
                ref_rf[a] = d;
            end
        for (int w = 0; w < no; w++)
            for (int b = 0; b < SERSZ; b++) begin
                a = (((ob + w) % 256) << 5) | b;
                exp_raddr.push_back(a);
                exp_res.push_back(ref_read(a));
            end
        cur_funcid = fid; cur_chip = ch;
        busy_dly = dly; busy_len = len;
        res_stall = rstall; res_hold = hold;
        start_cnt = 0; ren_cnt = 0; wen_cnt = 0; done_cnt = 0;
        start_cyc = -1; first_ren_cyc = -1; last_wen_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_funcid = 8'(fid); cmd_chip = 1'(ch);
        cmd_in_base = 8'(ib); cmd_nin = 12'(ni); cmd_out_base = 8'(ob); cmd_nout = 12'(no);
        fire = 1'b0;
        for (int k = 0; k < 200 && !fire; k++) begin
            #2 fire = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!fire) check_eq("cmd_timeout", fire, 1);
        for (int k = 0; k < 5000 && op_q.size() > 0; k++) begin
            op_valid = ($urandom_range(99) >= op_stall);
            op_data  = op_q[0];
            #2 fire = op_valid && op_ready;
            @(posedge clk);
            #1;
            if (fire) void'(op_q.pop_front());
        end
        op_valid = 1'b0;
        if (op_q.size() != 0) check_eq("op_timeout", op_q.size(), 0);
    endtask

    task automatic wait_done(input int no);
        for (int k = 0; k < 20000 && done_cnt == 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check_eq("done_count", done_cnt, 1);
        check_eq("start_count", start_cnt, 1);
        check_eq("wr_left", exp_waddr.size(), 0);
        check_eq("rd_left", exp_raddr.size(), 0);
        check_eq("res_left", exp_res.size(), 0);
        if (no > 0) check_eq("done_after_pop", done_cyc - last_pop_cyc, 1);
        else check_eq("no_reads", ren_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_funcid = 8'd0; cmd_chip = 1'b0;
        cmd_in_base = 8'd0; cmd_nin = 12'd0; cmd_out_base = 8'd0; cmd_nout = 12'd0;
        op_valid = 1'b0; op_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_handshakes", {op_ready, res_valid, res_last, job_done}, 0);
        check_eq("rst_m_ctl", {m_chip_sel, m_funcid, m_start, m_wen, m_ren, m_waddr, m_raddr}, 0);
        check_eq("rst_m_wdata", m_wdata, 0);
        rst_n = 1'b1;

        // Two-word load from base 5, no stalls.
        start_job(5, 2, 20, 1, 3, 1, 0, 0, 3, 10, 1'b0);
        wait_done(1);

        // Long busy pulse; reads begin the cycle after busy falls.
        start_job(30, 1, 9, 1, 7, 0, 0, 0, 3, 100, 1'b0);
        wait_done(1);
        check_eq("ren_after_busy", first_ren_cyc - start_cyc, 3 + 100 + 1);

        // Consumer stalled: read issue limited by FIFO credit.
        start_job(40, 1, 9, 4, 9, 0, 0, 0, 2, 5, 1'b1);
        for (int k = 0; k < 2000 && ren_cnt < RDQ; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        check_eq("rdq_credit_stall", ren_cnt, RDQ);
        res_hold = 1'b0;
        wait_done(4);

        // Word address wrap on both load and read.
        start_job(255, 2, 254, 3, 17, 1, 20, 30, 4, 8, 1'b0);
        wait_done(3);

        // Busy never rises: window timeout.
        start_job(10, 1, 10, 1, 33, 0, 0, 0, 3, 0, 1'b0);
        wait_done(1);
        check_eq("busy_window_read", first_ren_cyc - start_cyc, BUSY_WIN);
        start_job(0, 0, 0, 0, 44, 1, 0, 0, 3, 0, 1'b0);
        wait_done(0);
        check_eq("empty_job_done", done_cyc - start_cyc, BUSY_WIN);
        check_eq("empty_job_wen", wen_cnt, 0);

        // Random jobs.
        for (int j = 0; j < 8; j++) begin
            int no;
            no = $urandom_range(3);
            start_job($urandom_range(255), $urandom_range(3), $urandom_range(255), no,
                      $urandom_range(255), $urandom_range(1), $urandom_range(40),
                      $urandom_range(60), $urandom_range(10, 1), $urandom_range(30), 1'b0);
            wait_done(no);
        end

        // Reset while reads are in flight and beats are queued.
        start_job(100, 1, 100, 4, 5, 1, 0, 0, 2, 4, 1'b1);
        for (int k = 0; k < 2000 && ren_cnt < RDQ; k++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_res_valid", res_valid, 0);
        check_eq("mid_rst_cmd_ready", cmd_ready, 1);
        check_eq("mid_rst_m_ctl", {m_chip_sel, m_funcid, m_start, m_wen, m_ren, m_waddr, m_raddr}, 0);
        check_eq("mid_rst_m_wdata", m_wdata, 0);
        exp_waddr.delete(); exp_wdata.delete(); exp_raddr.delete(); exp_res.delete();
        res_hold = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #3;
            check_eq("post_rst_res_valid", res_valid, 0);
        end
        check_eq("post_rst_no_done", done_cnt, 0);
        start_job(7, 1, 7, 2, 66, 0, 10, 20, 3, 12, 1'b0);
        wait_done(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
